uart_boot_framer: RTL and testbench
===================================

Name: uart_boot_framer

Overview:
Framed program loader between the UART program receiver (byte stream, rx_dv/rx_byte) and the ICCM write port of the instruction memory adapter. It parses a sync/length/payload/checksum frame and assembles little-endian 32-bit words. Each word is written to the ICCM while the core is held in reset. The core is released only on a checksum-verified frame. It hardens the raw byte-to-word program path used at boot.

Parameters:
AddrWidth, 12, width of addr_o (ICCM word address)
MaxWords, 1024, largest accepted payload length in words
SyncByte, 8'hA5, frame start marker
TimeoutCycles, 100000, inter-byte timeout (used only with the optional feature)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
prog_i  input  1  program request level; its rising edge starts a load
rx_dv_i  input  1  one-cycle strobe, rx_byte_i valid
rx_byte_i  input  8  received byte
we_o  output  1  ICCM write strobe, one cycle per word
addr_o  output  AddrWidth  ICCM word address (word index, zero-extended)
wdata_o  output  32  ICCM write data
core_rst_o  output  1  active-high hold for the core/system reset
done_o  output  1  last load verified (sticky until next load)
err_o  output  1  last load failed (sticky until next load)

Behaviour:
- Reset: state IDLE. we_o=0, addr_o=0, wdata_o=0, core_rst_o=0, done_o=0, err_o=0, all counters and checksum cleared.
- prog_i is registered once. A detected rising edge from any state moves to SYNC, sets core_rst_o=1, and clears done_o, err_o, word counter and checksum. This restarts any load in progress.
- States:
  - IDLE: bytes ignored.
  - SYNC: a byte other than SyncByte is discarded. SyncByte moves to LEN0.
  - LEN0: the byte is len[7:0].
  - LEN1: the byte is len[15:8]. If len==0 or len>MaxWords, go to ERR; otherwise go to DATA.
  - DATA: bytes are assembled LSB first. On the 4th byte: we_o=1 for exactly one cycle (the cycle after the rx_dv_i that carried the byte), addr_o=word index, wdata_o=assembled word. Then the word index increments. After word len-1 is written, go to CSUM.
  - CSUM: compare the byte with the running XOR. Match goes to DONE, mismatch goes to ERR.
  - DONE: core_rst_o=0 (registered, one cycle after the checksum byte), done_o=1. Further bytes are ignored.
  - ERR: core_rst_o stays 1, err_o=1. Exit only through a prog_i rising edge or rst_i.
- Checksum: 8-bit XOR of every byte after SyncByte (len bytes and payload), excluding the checksum byte itself.
- Registers only act when rx_dv_i=1. Back-to-back rx_dv_i on consecutive cycles must be accepted with no byte loss.
- A prog_i rising edge and rx_dv_i in the same cycle: the restart wins and the byte is dropped.
- Words already written stay in ICCM on error. Only the core release is gated by the checksum.
- addr_o and wdata_o hold their last values when we_o=0.

Optional Feature:
UART_BOOT_FRAMER_TIMEOUT_EN
- Defined: a counter reloads on each rx_dv_i in states LEN0..CSUM. If TimeoutCycles clock cycles pass with no byte, go to ERR.
- Undefined: no timer. The block waits forever for the next byte.

Decomposition:
- boot_pkg holds:
  - the state enum (IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR),
  - the SYNC_BYTE constant,
  - the frame-field width constants.
- One sub-module, boot_word_assembler. It owns the 2-bit byte lane counter and 32-bit shift/assemble register, and outputs word_valid plus the word. Its clear input is driven on restart.

Test Plan:
- Reset, then prog_i rises. Send A5, 02, 00, 78 56 34 12, EF BE AD DE, checksum 0x02^0x00^0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE. Expect we_o at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF, then core_rst_o falls and done_o=1.
- Same frame with the checksum byte XORed by 0x01: expect two writes, err_o=1, core_rst_o held at 1. A later prog_i rising edge clears err_o.
- Garbage bytes 00 FF 5A before A5, then a valid 1-word frame: garbage ignored, exactly one write, done_o=1.
- len=0, and separately len=MaxWords+1 (01 04 for 1025): no we_o, err_o=1 right after LEN1.
- prog_i rises again midway through word 1 of a 2-word frame: state resets to SYNC, no partial write. A fresh valid frame starts writing at addr 0.
- With UART_BOOT_FRAMER_TIMEOUT_EN and TimeoutCycles=50: stop after A5 02: err_o=1 after 50 idle cycles. Without the macro, no error appears after 10000 cycles.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and frame-field constants for the UART boot framer.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         BYTE_W    = 8;
    localparam int         LEN_W     = 16;
    localparam int         WORD_W    = 32;
    localparam int         LANE_W    = 2;

endpackage

// File: rtl/uart_boot_framer_word_assembler.sv
// Packs payload bytes LSB-first into 32-bit words; word_valid_o fires combinationally with the 4th byte.
module boot_word_assembler
    import boot_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [LANE_W-1:0]        lane_q;
    logic [WORD_W-BYTE_W-1:0] shreg_q;

    assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, shreg_q};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else if (byte_valid_i) begin
            lane_q  <= lane_q + 2'd1;
            shreg_q <= {byte_i, shreg_q[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/uart_boot_framer.sv
// Sync/length/payload/XOR-checksum program loader feeding the ICCM while holding the core in reset.
// Optional inter-byte timeout: define UART_BOOT_FRAMER_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no load requested, bytes ignored
//   SYNC  | hunting for the sync byte
//   LEN0  | expecting len[7:0]
//   LEN1  | expecting len[15:8], range-checked
//   DATA  | assembling and writing payload words
//   CSUM  | expecting checksum byte
//   DONE  | frame verified, core released
//   ERR   | load failed, core held until next request
module uart_boot_framer
    import boot_pkg::*;
#(
    parameter int          AddrWidth     = 12,
    parameter int          MaxWords      = 1024,
    parameter logic [7:0]  SyncByte      = SYNC_BYTE,
    parameter int          TimeoutCycles = 100000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 prog_i,
    input  logic                 rx_dv_i,
    input  logic [BYTE_W-1:0]    rx_byte_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [WORD_W-1:0]    wdata_o,
    output logic                 core_rst_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MaxWords);
    localparam logic [31:0]      TO_RELOAD = 32'(TimeoutCycles - 1);

    boot_state_e state_q, state_d;

    logic              prog_q;
    logic              restart;
    logic              byte_ok;
    logic [BYTE_W-1:0] len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_full;
    logic [LEN_W-1:0]  word_idx_q;
    logic [BYTE_W-1:0] csum_q;
    logic              asm_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              last_word;
    logic              timeout;

    // A restart in the same cycle as a byte drops that byte.
    assign restart   = prog_i && !prog_q;
    assign byte_ok   = rx_dv_i && !restart;
    assign len_full  = {rx_byte_i, len_lo_q};
    assign asm_valid = byte_ok && (state_q == ST_DATA);
    assign last_word = word_valid && (word_idx_q == (len_q - 16'd1));

    boot_word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (restart),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_byte_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef UART_BOOT_FRAMER_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        active;

    assign active  = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
    assign timeout = active && !rx_dv_i && (to_cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || rx_dv_i || !active) begin
            to_cnt_q <= TO_RELOAD;
        end else if (to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 32'd1;
        end
    end
`else
    logic unused_to;
    assign unused_to = ^TO_RELOAD;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_SYNC;
        end else if (timeout) begin
            state_d = ST_ERR;
        end else if (byte_ok) begin
            case (state_q)
                ST_SYNC: if (rx_byte_i == SyncByte) state_d = ST_LEN0;
                ST_LEN0: state_d = ST_LEN1;
                ST_LEN1: begin
                    if (len_full == '0 || len_full > MAX_LEN) state_d = ST_ERR;
                    else                                       state_d = ST_DATA;
                end
                ST_DATA: if (last_word) state_d = ST_CSUM;
                ST_CSUM: state_d = (rx_byte_i == csum_q) ? ST_DONE : ST_ERR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            prog_q     <= 1'b0;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            we_o       <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            core_rst_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            prog_q  <= prog_i;
            state_q <= state_d;
            we_o    <= 1'b0;
            if (restart) begin
                core_rst_o <= 1'b1;
                done_o     <= 1'b0;
                err_o      <= 1'b0;
                word_idx_q <= '0;
                csum_q     <= '0;
                len_lo_q   <= '0;
                len_q      <= '0;
            end else begin
                if (byte_ok) begin
                    case (state_q)
                        ST_LEN0: begin
                            len_lo_q <= rx_byte_i;
                            csum_q   <= csum_q ^ rx_byte_i;
                        end
                        ST_LEN1: begin
                            len_q  <= len_full;
                            csum_q <= csum_q ^ rx_byte_i;
                        end
                        ST_DATA: begin
                            csum_q <= csum_q ^ rx_byte_i;
                            if (word_valid) begin
                                we_o       <= 1'b1;
                                addr_o     <= AddrWidth'(word_idx_q);
                                wdata_o    <= word;
                                word_idx_q <= word_idx_q + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                // Only the checksum-verified transition releases the core.
                if (state_d == ST_DONE) begin
                    core_rst_o <= 1'b0;
                    done_o     <= 1'b1;
                end
                if (state_d == ST_ERR) err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_framer.sv
// Scoreboard bench for uart_boot_framer: expected ICCM writes queued at stimulus time, popped on we_o.
module tb_uart_boot_framer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        prog_i;
    logic        rx_dv_i;
    logic [7:0]  rx_byte_i;
    logic        we_o;
    logic [11:0] addr_o;
    logic [31:0] wdata_o;
    logic        core_rst_o;
    logic        done_o;
    logic        err_o;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] wq[$];
    logic [7:0]  bq[$];
    int          total = 0;
    int          bad   = 0;
    int          n_wr  = 0;

    always #5 clk_i = ~clk_i;

`ifdef UART_BOOT_FRAMER_TIMEOUT_EN
    localparam int TO_CYC = 50;
`else
    localparam int TO_CYC = 100000;
`endif

    uart_boot_framer #(
        .AddrWidth     (12),
        .MaxWords      (1024),
        .SyncByte      (8'hA5),
        .TimeoutCycles (TO_CYC)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prog_i     (prog_i),
        .rx_dv_i    (rx_dv_i),
        .rx_byte_i  (rx_byte_i),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .core_rst_o (core_rst_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (we_o === 1'b1) begin
            wr_t e;
            n_wr++;
            if (sb.size() == 0) begin
                chk_val("unexpected_we", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk_val("we_addr", 64'(addr_o), 64'(e.addr));
                chk_val("we_data", 64'(wdata_o), 64'(e.data));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_prog();
        prog_i = 1'b0;
        cycles(2);
        prog_i = 1'b1;
        cycles(2);
    endtask

    // Sends bq back-to-back, one byte per cycle.
    task automatic tx();
        while (bq.size() > 0) begin
            rx_dv_i   = 1'b1;
            rx_byte_i = bq.pop_front();
            cycles(1);
        end
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
    endtask

    // Builds a frame from wq, queues expected writes, optionally corrupts the checksum.
    task automatic send_frame(input logic [7:0] flip);
        logic [7:0]  cs;
        logic [15:0] len;
        logic [31:0] w;
        logic [7:0]  b;
        cs  = 8'h00;
        len = 16'(wq.size());
        bq.push_back(8'hA5);
        bq.push_back(len[7:0]);
        bq.push_back(len[15:8]);
        cs = len[7:0] ^ len[15:8];
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                bq.push_back(b);
                cs ^= b;
            end
            sb.push_back('{addr: 12'(i), data: w});
        end
        bq.push_back(cs ^ flip);
        tx();
    endtask

    initial begin
        rst_i     = 1'b1;
        prog_i    = 1'b0;
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
        cycles(3);
        chk_val("rst_we", 64'(we_o), 64'd0);
        chk_val("rst_addr", 64'(addr_o), 64'd0);
        chk_val("rst_wdata", 64'(wdata_o), 64'd0);
        chk_val("rst_core_rst", 64'(core_rst_o), 64'd0);
        chk_val("rst_done", 64'(done_o), 64'd0);
        chk_val("rst_err", 64'(err_o), 64'd0);
        rst_i = 1'b0;
        cycles(2);

        // Idle bytes are ignored before any request.
        bq = {8'hA5, 8'h01, 8'h00};
        tx();
        chk_val("idle_core_rst", 64'(core_rst_o), 64'd0);

        // Good two-word frame.
        pulse_prog();
        chk_val("prog_core_rst", 64'(core_rst_o), 64'd1);
        n_wr = 0;
        wq = {32'h12345678, 32'hDEADBEEF};
        send_frame(8'h00);
        cycles(1);
        chk_val("ok_done", 64'(done_o), 64'd1);
        chk_val("ok_core_rst", 64'(core_rst_o), 64'd0);
        chk_val("ok_err", 64'(err_o), 64'd0);
        chk_val("ok_nwr", 64'(n_wr), 64'd2);
        chk_val("hold_addr", 64'(addr_o), 64'd1);
        chk_val("hold_wdata", 64'(wdata_o), 64'hDEADBEEF);
        chk_val("ok_sb_empty", 64'(sb.size()), 64'd0);

        // Bad checksum.
        pulse_prog();
        chk_val("restart_done_clr", 64'(done_o), 64'd0);
        n_wr = 0;
        send_frame(8'h01);
        cycles(1);
        chk_val("bad_err", 64'(err_o), 64'd1);
        chk_val("bad_core_rst", 64'(core_rst_o), 64'd1);
        chk_val("bad_done", 64'(done_o), 64'd0);
        chk_val("bad_nwr", 64'(n_wr), 64'd2);
        pulse_prog();
        chk_val("bad_err_clr", 64'(err_o), 64'd0);

        // Garbage ahead of sync, one-word frame.
        n_wr = 0;
        bq = {8'h00, 8'hFF, 8'h5A};
        tx();
        wq = {32'hCAFEF00D};
        send_frame(8'h00);
        cycles(1);
        chk_val("garb_nwr", 64'(n_wr), 64'd1);
        chk_val("garb_done", 64'(done_o), 64'd1);

        // len = 0 and len = MaxWords+1.
        pulse_prog();
        n_wr = 0;
        bq = {8'hA5, 8'h00, 8'h00};
        tx();
        chk_val("len0_err", 64'(err_o), 64'd1);
        pulse_prog();
        bq = {8'hA5, 8'h01, 8'h04};
        tx();
        chk_val("len1025_err", 64'(err_o), 64'd1);
        bq = {8'h11, 8'h22, 8'h33, 8'h44};
        tx();
        cycles(1);
        chk_val("len_nwr", 64'(n_wr), 64'd0);

        // Restart in the middle of word 1, then a fresh frame starting at addr 0.
        pulse_prog();
        n_wr = 0;
        sb.push_back('{addr: 12'd0, data: 32'h12345678});
        bq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        tx();
        pulse_prog();
        wq = {32'h11223344};
        send_frame(8'h00);
        cycles(1);
        chk_val("mid_nwr", 64'(n_wr), 64'd2);
        chk_val("mid_done", 64'(done_o), 64'd1);
        chk_val("mid_sb_empty", 64'(sb.size()), 64'd0);

        // Restart coincident with a sync byte: the sync byte is dropped.
        prog_i = 1'b0;
        cycles(2);
        prog_i    = 1'b1;
        rx_dv_i   = 1'b1;
        rx_byte_i = 8'hA5;
        cycles(1);
        rx_dv_i = 1'b0;
        n_wr = 0;
        bq = {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01};
        tx();
        cycles(1);
        chk_val("coll_nwr", 64'(n_wr), 64'd0);
        chk_val("coll_done", 64'(done_o), 64'd0);
        chk_val("coll_core_rst", 64'(core_rst_o), 64'd1);

        // Stall after A5 02.
        pulse_prog();
        bq = {8'hA5, 8'h02};
        tx();
`ifdef UART_BOOT_FRAMER_TIMEOUT_EN
        cycles(40);
        chk_val("to_early_err", 64'(err_o), 64'd0);
        cycles(20);
        chk_val("to_err", 64'(err_o), 64'd1);
`else
        cycles(10000);
        chk_val("noto_err", 64'(err_o), 64'd0);
`endif
        chk_val("stall_core_rst", 64'(core_rst_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
